tdm_demux_rx: RTL and testbench
===============================

// Module: tdm_demux_rx
// PURPOSE
//  Receive end of the team's serial time-division mux link: takes a 1-bit,
//  MSB-first, slot-interleaved stream with a frame-sync marker and
//  distributes each slot to its own parallel channel register.
//  Sits between the link input pins and per-channel consumers.
//  Counterpart to the gate-level/TDM mux transmit path.
// PARAMETERS
//  NUM_CH     4  channels per frame (2..16)
//  SLOT_BITS  8  bits per channel slot (2..32)
// PORTS
//  clk        in   1                  rising-edge clock
//  rst_n      in   1                  asynchronous active-low reset
//  en         in   1                  sdata/fsync valid this cycle; en=0 stalls
//  sdata      in   1                  serial data bit, MSB of slot first
//  fsync      in   1                  with en: this bit = MSB of channel 0
//  ch_data    out  NUM_CH*SLOT_BITS   channel k in bits [k*SLOT_BITS +: SLOT_BITS]
//  ch_valid   out  NUM_CH             one-cycle pulse: slice k updated
//  frame_done out  1                  one-cycle pulse: last channel written
//  sync_err   out  1                  one-cycle pulse: framing violation
//  locked     out  1                  high while in RECV state
// BEHAVIOUR
//  - Reset (async assert, sync deassert): state=HUNT, ch_data=0,
//    ch_valid=0, frame_done=0, sync_err=0, locked=0, counters=0.
//  - All outputs registered. Only edges with en=1 act; en=0 holds everything
//    and clears ch_valid/frame_done/sync_err.
//  - HUNT: ignore sdata until en&fsync; then shift in sdata as bit 0 of ch 0,
//    bit_cnt=1, ch_cnt=0, go RECV (locked=1 next cycle).
//  - RECV, en=1, fsync=0, not frame boundary: shift sdata into shift reg,
//    bit_cnt++.
//  - Slot complete (edge sampling bit SLOT_BITS-1): ch_data slice[ch_cnt]
//    <= full SLOT_BITS word, ch_valid[ch_cnt]=1 for one cycle, bit_cnt=0,
//    ch_cnt++. Other slices hold. Latency: data visible 1 cycle after the
//    edge sampling the last bit (same cycle as ch_valid).
//  - Last channel complete: additionally frame_done=1 that cycle; ch_cnt
//    wraps to 0; FSM expects fsync on the next en bit.
//  - Frame boundary, en=1, fsync=1: normal; bit taken as MSB of ch 0.
//  - Frame boundary, en=1, fsync=0: sync_err=1, bit discarded, go HUNT.
//  - Mid-frame fsync (en=1, not boundary): sync_err=1, partial slot
//    discarded, no ch_valid; restart frame with this bit as ch0 MSB
//    (stay RECV).
//  - SLOT_BITS=1-bit-per-edge; no back-to-back restrictions; ch_valid and
//    frame_done may coincide. sync_err never coincides with ch_valid.
//  - Reset mid-frame: partial data lost, all outputs to reset values.
// TESTING (NUM_CH=4, SLOT_BITS=8)
//  1 Reset, en=1 fsync pulses absent, random sdata 20 cycles -> locked=0,
//    ch_valid=0, ch_data=0.
//  2 Frame A5,3C,FF,00 with fsync on first bit, en=1 continuous ->
//    ch_valid pulses 0001,0010,0100,1000 every 8 cycles; ch_data=32'h00FF3CA5;
//    frame_done with last pulse.
//  3 Same frame with en toggling 1/0 every cycle -> identical outputs, pulses
//    spaced 16 cycles, no sync_err.
//  4 Two frames back-to-back, second omits fsync -> frame 1 delivered,
//    sync_err=1 on frame 2 first bit, locked drops, ch_data holds frame 1.
//  5 fsync reasserted at bit 3 of ch 2 -> sync_err pulse, ch2 not written;
//    following 32 bits (12,34,56,78) give ch_data=32'h78563412.
//  6 rst_n low at bit 5 of ch 1 for 1 cycle -> all outputs 0 immediately,
//    locked=0; next fsync frame received correctly.

Source files
------------

// File: rtl/tdm_demux_rx.sv
// ----------------------------------------------------------------------------
// tdm_demux_rx
//   Receive side of the serial TDM link. A 1-bit, MSB-first, slot-interleaved
//   stream is framed by fsync, which marks the MSB of channel 0. Each completed
//   slot is written into its own slice of ch_data. Framing violations are
//   flagged on sync_err.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   sdata/fsync valid this cycle (en=0 stalls the receiver)
//   sdata      in   serial data bit, MSB of each slot first
//   fsync      in   with en: this bit is the MSB of channel 0
//   ch_data    out  channel k in bits [k*SLOT_BITS +: SLOT_BITS]
//   ch_valid   out  one-cycle pulse per channel: slice k was just updated
//   frame_done out  one-cycle pulse: the last channel of a frame was written
//   sync_err   out  one-cycle pulse: framing violation detected
//   locked     out  high while the receiver is aligned to a frame (RECV)
// ----------------------------------------------------------------------------
module tdm_demux_rx #(
    parameter int NUM_CH    = 4,
    parameter int SLOT_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        sdata,
    input  logic                        fsync,
    output logic [NUM_CH*SLOT_BITS-1:0] ch_data,
    output logic [NUM_CH-1:0]           ch_valid,
    output logic                        frame_done,
    output logic                        sync_err,
    output logic                        locked
);

    localparam int BIT_W = $clog2(SLOT_BITS);
    localparam int CH_W  = $clog2(NUM_CH);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t                      state_q,      state_d;
    // Only SLOT_BITS-1 bits are stored: the final bit of a slot is taken
    // straight from sdata on the edge that completes the word.
    logic [SLOT_BITS-2:0]        shift_q,      shift_d;
    logic [BIT_W-1:0]            bit_cnt_q,    bit_cnt_d;
    logic [CH_W-1:0]             ch_cnt_q,     ch_cnt_d;
    logic [NUM_CH*SLOT_BITS-1:0] ch_data_q,    ch_data_d;
    logic [NUM_CH-1:0]           ch_valid_q,   ch_valid_d;
    logic                        frame_done_q, frame_done_d;
    logic                        sync_err_q,   sync_err_d;

    logic [SLOT_BITS-1:0] word;
    logic                 last_bit;
    logic                 last_ch;
    logic                 boundary;

    assign word     = {shift_q, sdata};
    assign last_bit = (bit_cnt_q == BIT_W'(SLOT_BITS - 1));
    assign last_ch  = (ch_cnt_q == CH_W'(NUM_CH - 1));
    // Both counters at zero while locked means the previous frame just ended
    // and the next enabled bit must carry fsync.
    assign boundary = (bit_cnt_q == '0) && (ch_cnt_q == '0);

    // Next-state / output logic.
    // NOTE: every signal gets a default before any branch; a path that leaves
    // a combinational variable unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        ch_cnt_d     = ch_cnt_q;
        ch_data_d    = ch_data_q;
        ch_valid_d   = '0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (en) begin
            unique case (state_q)
                HUNT: begin
                    if (fsync) begin
                        shift_d    = '0;
                        shift_d[0] = sdata;
                        bit_cnt_d  = BIT_W'(1);
                        ch_cnt_d   = '0;
                        state_d    = RECV;
                    end
                end

                RECV: begin
                    if (fsync) begin
                        // A frame start: clean at the boundary, otherwise the
                        // partial slot is dropped and the frame restarts here.
                        sync_err_d = !boundary;
                        shift_d    = '0;
                        shift_d[0] = sdata;
                        bit_cnt_d  = BIT_W'(1);
                        ch_cnt_d   = '0;
                    end else if (boundary) begin
                        // Missing fsync where one was due: lose lock.
                        sync_err_d = 1'b1;
                        bit_cnt_d  = '0;
                        ch_cnt_d   = '0;
                        state_d    = HUNT;
                    end else if (last_bit) begin
                        ch_data_d[ch_cnt_q*SLOT_BITS +: SLOT_BITS] = word;
                        ch_valid_d[ch_cnt_q] = 1'b1;
                        bit_cnt_d            = '0;
                        if (last_ch) begin
                            ch_cnt_d     = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            ch_cnt_d = ch_cnt_q + CH_W'(1);
                        end
                    end else begin
                        shift_d   = word[SLOT_BITS-2:0];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end

                default: state_d = HUNT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            ch_cnt_q     <= '0;
            ch_data_q    <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            ch_cnt_q     <= ch_cnt_d;
            ch_data_q    <= ch_data_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign ch_data    = ch_data_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == RECV);

endmodule

// File: tb/tb_tdm_demux_rx.sv
// ----------------------------------------------------------------------------
// tb_tdm_demux_rx
//   Directed bench for tdm_demux_rx (NUM_CH=4, SLOT_BITS=8). The stimulus
//   side queues the event each bit is expected to cause; an independent
//   monitor pops an entry whenever the DUT pulses ch_valid, frame_done or
//   sync_err and compares the whole output picture, including the spacing
//   in cycles since the previous event.
// ----------------------------------------------------------------------------
module tb_tdm_demux_rx;

    localparam int NUM_CH    = 4;
    localparam int SLOT_BITS = 8;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sdata;
    logic        fsync;
    logic [31:0] ch_data;
    logic [3:0]  ch_valid;
    logic        frame_done;
    logic        sync_err;
    logic        locked;

    tdm_demux_rx #(
        .NUM_CH   (NUM_CH),
        .SLOT_BITS(SLOT_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sdata     (sdata),
        .fsync     (fsync),
        .ch_data   (ch_data),
        .ch_valid  (ch_valid),
        .frame_done(frame_done),
        .sync_err  (sync_err),
        .locked    (locked)
    );

    typedef struct packed {
        logic [3:0]  v;
        logic        fd;
        logic        se;
        logic        lk;
        logic [31:0] data;
        int          gap;   // required cycles since previous event, 0 = don't care
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_data;
    int          total;
    int          bad;
    int          cyc;
    int          last_evt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: one queue entry per output event.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (ch_valid != 4'b0 || frame_done || sync_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {25'b0, ch_valid, frame_done, sync_err, locked, ch_data},
                      64'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event", {25'b0, ch_valid, frame_done, sync_err, locked, ch_data},
                      {25'b0, e.v, e.fd, e.se, e.lk, e.data});
                if (e.gap != 0)
                    check("event_gap", 64'(cyc - last_evt), 64'(e.gap));
            end
            last_evt = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // One clock of input; returns just after the sampling edge.
    task automatic drive(input logic e, input logic b, input logic fs);
        en    = e;
        sdata = b;
        fsync = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic push_evt(input logic [3:0] v, input logic fd, input logic se,
                            input logic lk, input int gap);
        exp_t e;
        e.v    = v;
        e.fd   = fd;
        e.se   = se;
        e.lk   = lk;
        e.data = exp_data;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // Send one slot MSB first. fs_first raises fsync on the MSB; err_first
    // says that fsync lands mid-frame and must raise sync_err.
    task automatic send_slot(input logic [7:0] val, input int k, input bit fs_first,
                             input bit err_first, input bit toggle, input int gap);
        for (int i = 7; i >= 0; i--) begin
            if (i == 7 && err_first)
                push_evt(4'b0000, 1'b0, 1'b1, 1'b1, 0);
            if (i == 0) begin
                exp_data[k*8 +: 8] = val;
                push_evt(4'b0001 << k, (k == 3), 1'b0, 1'b1, gap);
            end
            drive(1'b1, val[i], (i == 7) && fs_first);
            if (toggle)
                drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input bit toggle, input int gap);
        send_slot(w[7:0],   0, 1'b1, 1'b0, toggle, 0);
        send_slot(w[15:8],  1, 1'b0, 1'b0, toggle, gap);
        send_slot(w[23:16], 2, 1'b0, 1'b0, toggle, gap);
        send_slot(w[31:24], 3, 1'b0, 1'b0, toggle, gap);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cyc      = 0;
        last_evt = 0;
        exp_data = 32'h0;
        en       = 1'b0;
        sdata    = 1'b0;
        fsync    = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {26'b0, locked, ch_valid, frame_done, sync_err, ch_data}, 64'b0);
        rst_n = 1'b1;

        // 1: no fsync, random data -> stays in HUNT, outputs quiet.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            check("t1_hunt_idle", {27'b0, locked, ch_valid, ch_data}, 64'b0);
        end

        // 2: continuous frame.
        send_frame(32'h00FF3CA5, 1'b0, 8);
        check("t2_ch_data", 64'(ch_data), 64'h00FF3CA5);
        check("t2_locked", 64'(locked), 64'd1);

        // 3: same frame, en toggling.
        send_frame(32'h00FF3CA5, 1'b1, 16);
        check("t3_ch_data", 64'(ch_data), 64'h00FF3CA5);

        // 4: frame 1 good, frame 2 misses fsync at its first bit.
        send_frame(32'h44332211, 1'b0, 8);
        push_evt(4'b0000, 1'b0, 1'b1, 1'b0, 1);
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 31; i++)
            drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        check("t4_unlocked", 64'(locked), 64'd0);
        check("t4_ch_data_held", 64'(ch_data), 64'h44332211);

        // 5: fsync reasserted at bit 3 of ch 2; frame restarts there.
        send_slot(8'hAA, 0, 1'b1, 1'b0, 1'b0, 0);
        send_slot(8'hBB, 1, 1'b0, 1'b0, 1'b0, 8);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        send_slot(8'h12, 0, 1'b1, 1'b1, 1'b0, 0);
        send_slot(8'h34, 1, 1'b0, 1'b0, 1'b0, 8);
        send_slot(8'h56, 2, 1'b0, 1'b0, 1'b0, 8);
        send_slot(8'h78, 3, 1'b0, 1'b0, 1'b0, 8);
        check("t5_ch_data", 64'(ch_data), 64'h78563412);

        // 6: reset at bit 5 of ch 1, then a clean frame.
        send_slot(8'h5A, 0, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 7; i >= 3; i--)
            drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", {26'b0, locked, ch_valid, frame_done, sync_err, ch_data}, 64'b0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        exp_data = 32'h0;
        send_frame(32'hF0DEBC9A, 1'b0, 8);
        check("t6_ch_data", 64'(ch_data), 64'hF0DEBC9A);
        check("t6_locked", 64'(locked), 64'd1);

        repeat (4) drive(1'b0, 1'b0, 1'b0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
